clk_ratio_meter: RTL and testbench

//  Receive-side companion to the divide-by-N clock generator. Samples a divided clock
//  (clk_in) in the clk domain and measures its period and high time in clk cycles.

---
 rtl/clk_ratio_meter_pkg.sv | 15 +
 rtl/clk_ratio_meter_sync_edge_det.sv | 32 +++
 rtl/clk_ratio_meter.sv | 196 +++++++++++++++++++
 tb/tb_clk_ratio_meter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_ratio_meter_pkg.sv
// Shared types and helpers for the divided-clock ratio meter.
package clk_ratio_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        MEASURE
    } meter_state_e;

    // Bits needed to hold counts 0..max inclusive.
    function automatic int cnt_w(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/clk_ratio_meter_sync_edge_det.sv
// Brings the asynchronous divided clock into the clk domain and turns its
// synchronized level into single-cycle rise/fall pulses.
module clk_ratio_meter_sync_edge_det
    import clk_ratio_meter_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    // Both pulses come from the same delayed pair, so edges keep equal latency.
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures period and high time of a divided clock in clk cycles, tracks lock
// on a stable ratio and flags ratio mismatch, duty error and loss of clock.
module clk_ratio_meter
    import clk_ratio_meter_pkg::*;
#(
    parameter  int MAX_N       = 256,
    parameter  int LOCK_CNT    = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int CW          = cnt_w(MAX_N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          clk_in,
    input  logic [CW-1:0] expected_n,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_time,
    output logic          period_valid,
    output logic          locked,
    output logic          mismatch,
    output logic          duty_err,
    output logic          timeout
);

    localparam int             LW       = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(MAX_N);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [LW-1:0]  LOCK_MAX = LW'(LOCK_CNT);
    localparam logic [LW-1:0]  LOCK_ONE = LW'(1);

    // |2*hi - per| > 1, evaluated one bit wider so 2*hi cannot wrap.
    function automatic logic duty_bad(input logic [CW-1:0] hi, input logic [CW-1:0] per);
        logic [CW:0] twice;
        logic [CW:0] per_w;
        logic [CW:0] diff;
        twice = {hi, 1'b0};
        per_w = {1'b0, per};
        diff  = (twice >= per_w) ? (twice - per_w) : (per_w - twice);
        return diff > (CW+1)'(1);
    endfunction

    logic rise;
    logic fall;

    clk_ratio_meter_sync_edge_det #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (clk_in),
        .rise_o(rise),
        .fall_o(fall)
    );

    meter_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] hi_cap_q, hi_cap_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] high_q, high_d;
    logic          pv_q, pv_d;
    logic          mis_q, mis_d;
    logic          duty_q, duty_d;
    logic          tmo_q, tmo_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic [CW-1:0] hi_sel;
    logic          meas_to;
    logic          wait_to;

    assign meas_to = (state_q == MEASURE) && !rise && (cnt_q == CNT_MAX);
    assign wait_to = (state_q == WAIT_EDGE) && !rise && (wcnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      state_d = WAIT_EDGE;
                WAIT_EDGE: if (rise) state_d = MEASURE;
                MEASURE:   if (meas_to) state_d = WAIT_EDGE;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        wcnt_d     = wcnt_q;
        hi_cap_d   = hi_cap_q;
        period_d   = period_q;
        high_d     = high_q;
        pv_d       = 1'b0;
        mis_d      = mis_q;
        duty_d     = duty_q;
        tmo_d      = tmo_q;
        lock_cnt_d = lock_cnt_q;
        // A fall landing on the rise cycle means no measurable high phase.
        hi_sel     = fall ? '0 : hi_cap_q;
        if (!enable) begin
            cnt_d      = '0;
            wcnt_d     = '0;
            hi_cap_d   = '0;
            period_d   = '0;
            high_d     = '0;
            mis_d      = 1'b0;
            duty_d     = 1'b0;
            tmo_d      = 1'b0;
            lock_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d  = CNT_ONE;
                    wcnt_d = CNT_ONE;
                end
                WAIT_EDGE: begin
                    cnt_d = CNT_ONE;
                    if (rise) begin
                        wcnt_d = CNT_ONE;
                    end else if (wait_to) begin
                        tmo_d      = 1'b1;
                        lock_cnt_d = '0;
                        wcnt_d     = CNT_ONE;
                    end else begin
                        wcnt_d = wcnt_q + CNT_ONE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d = cnt_q;
                        high_d   = hi_sel;
                        pv_d     = 1'b1;
                        mis_d    = (cnt_q != expected_n);
                        duty_d   = fall | duty_bad(hi_sel, cnt_q);
                        cnt_d    = CNT_ONE;
                        if (cnt_q != period_q)
                            lock_cnt_d = LOCK_ONE;
                        else if (lock_cnt_q != LOCK_MAX)
                            lock_cnt_d = lock_cnt_q + LOCK_ONE;
                    end else if (meas_to) begin
                        tmo_d      = 1'b1;
                        lock_cnt_d = '0;
                        cnt_d      = CNT_ONE;
                        wcnt_d     = CNT_ONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (fall) hi_cap_d = cnt_q;
                    end
                end
                default: begin
                    cnt_d = CNT_ONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            wcnt_q     <= '0;
            hi_cap_q   <= '0;
            period_q   <= '0;
            high_q     <= '0;
            pv_q       <= 1'b0;
            mis_q      <= 1'b0;
            duty_q     <= 1'b0;
            tmo_q      <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            hi_cap_q   <= hi_cap_d;
            period_q   <= period_d;
            high_q     <= high_d;
            pv_q       <= pv_d;
            mis_q      <= mis_d;
            duty_q     <= duty_d;
            tmo_q      <= tmo_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign period       = period_q;
    assign high_time    = high_q;
    assign period_valid = pv_q;
    assign locked       = (lock_cnt_q == LOCK_MAX);
    assign mismatch     = mis_q;
    assign duty_err     = duty_q;
    assign timeout      = tmo_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Bench for clk_ratio_meter: edge-timestamp reference model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_clk_ratio_meter;

    localparam int MAX_N    = 16;
    localparam int LOCK_CNT = 4;
    localparam int S        = 2;
    localparam int CW       = $clog2(MAX_N + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          clk_in;
    logic [CW-1:0] expected_n;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          period_valid;
    logic          locked;
    logic          mismatch;
    logic          duty_err;
    logic          timeout;

    always #5 clk = ~clk;

    clk_ratio_meter #(
        .MAX_N      (MAX_N),
        .LOCK_CNT   (LOCK_CNT),
        .SYNC_STAGES(S)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .clk_in      (clk_in),
        .expected_n  (expected_n),
        .period      (period),
        .high_time   (high_time),
        .period_valid(period_valid),
        .locked      (locked),
        .mismatch    (mismatch),
        .duty_err    (duty_err),
        .timeout     (timeout)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference model: the meter sees each sampled clk_in edge S edges later;
    // periods and high times are differences of those edge timestamps.
    bit hist[0:7];
    int mode;
    int wstart, rstart, hi_cap, lock_n;
    int m_period, m_high;
    bit m_pv, m_mis, m_duty, m_tmo;

    initial begin
        int d, el, hi;
        bit h, rise, fall;
        for (int i = 0; i < 8; i++) hist[i] = 1'b0;
        mode = 0; wstart = 0; rstart = 0; hi_cap = 0; lock_n = 0;
        m_period = 0; m_high = 0; m_pv = 0; m_mis = 0; m_duty = 0; m_tmo = 0;
        forever begin
            @(posedge clk);
            cyc++;
            h    = reset ? 1'b0 : clk_in;
            rise = hist[S-1] && !hist[S];
            fall = !hist[S-1] && hist[S];
            for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = h;
            m_pv = 0;
            if (reset || !enable) begin
                mode = 0; hi_cap = 0; lock_n = 0;
                m_period = 0; m_high = 0; m_mis = 0; m_duty = 0; m_tmo = 0;
            end else if (mode == 0) begin
                mode = 1; wstart = cyc;
            end else if (mode == 1) begin
                if (rise) begin
                    mode = 2; rstart = cyc;
                end else if (cyc - wstart == MAX_N) begin
                    m_tmo = 1; lock_n = 0; wstart = cyc;
                end
            end else begin
                el = cyc - rstart;
                if (rise) begin
                    hi = fall ? 0 : hi_cap;
                    d  = 2 * hi - el;
                    if (d < 0) d = -d;
                    m_pv   = 1;
                    m_mis  = (el != int'(expected_n));
                    m_duty = fall || (d > 1);
                    if (el == m_period) lock_n = (lock_n < LOCK_CNT) ? lock_n + 1 : LOCK_CNT;
                    else lock_n = 1;
                    m_period = el; m_high = hi; rstart = cyc;
                end else if (el == MAX_N) begin
                    m_tmo = 1; lock_n = 0; mode = 1; wstart = cyc;
                end else if (fall) begin
                    hi_cap = el;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("period",       int'(period),    m_period);
            chk("high_time",    int'(high_time), m_high);
            chk("period_valid", int'(period_valid), int'(m_pv));
            chk("locked",       int'(locked),    int'(lock_n == LOCK_CNT));
            chk("mismatch",     int'(mismatch),  int'(m_mis));
            chk("duty_err",     int'(duty_err),  int'(m_duty));
            chk("timeout",      int'(timeout),   int'(m_tmo));
        end
    end

    task automatic run_div(input int n, input int hi, input int k);
        for (int p = 0; p < k; p++) begin
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                clk_in = (i < hi);
            end
        end
    endtask

    task automatic hold(input bit lvl, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clk_in = lvl;
        end
    endtask

    initial begin
        int kind, n, hi, k;
        reset = 1'b1; enable = 1'b0; clk_in = 1'b0; expected_n = '0;
        repeat (4) @(negedge clk);
        chk("rst_period",   int'(period), 0);
        chk("rst_high",     int'(high_time), 0);
        chk("rst_pv",       int'(period_valid), 0);
        chk("rst_locked",   int'(locked), 0);
        chk("rst_mismatch", int'(mismatch), 0);
        chk("rst_duty",     int'(duty_err), 0);
        chk("rst_timeout",  int'(timeout), 0);
        reset = 1'b0; enable = 1'b1; expected_n = CW'(4);

        run_div(4, 2, 8);
        chk("div4_period", int'(period), 4);
        chk("div4_high",   int'(high_time), 2);
        chk("div4_locked", int'(locked), 1);
        chk("div4_mis",    int'(mismatch), 0);
        chk("div4_duty",   int'(duty_err), 0);

        expected_n = CW'(7);
        run_div(7, 4, 8);
        chk("div7_period", int'(period), 7);
        chk("div7_high",   int'(high_time), 4);
        chk("div7_duty",   int'(duty_err), 0);
        chk("div7_locked", int'(locked), 1);

        expected_n = CW'(5);
        run_div(4, 2, 8);
        chk("exp5_period", int'(period), 4);
        chk("exp5_mis",    int'(mismatch), 1);
        chk("exp5_locked", int'(locked), 1);

        expected_n = CW'(6);
        run_div(6, 3, 2);
        chk("sw6_period", int'(period), 6);
        chk("sw6_unlock", int'(locked), 0);
        run_div(6, 3, 4);
        chk("sw6_relock", int'(locked), 1);

        hold(1'b0, 30);
        chk("lost_timeout", int'(timeout), 1);
        chk("lost_locked",  int'(locked), 0);
        @(negedge clk); enable = 1'b0;
        @(negedge clk);
        chk("en_clr_timeout", int'(timeout), 0);
        chk("en_clr_period",  int'(period), 0);
        enable = 1'b1;

        expected_n = CW'(5);
        run_div(5, 2, 4);
        hold(1'b1, 1);
        hold(1'b0, 2);
        reset = 1'b1;
        hold(1'b0, 3);
        chk("midrst_period", int'(period), 0);
        chk("midrst_pv",     int'(period_valid), 0);
        reset = 1'b0;
        run_div(5, 2, 5);

        for (int seg = 0; seg < 30; seg++) begin
            kind = $urandom_range(0, 9);
            case (kind)
                0: begin
                    @(negedge clk); enable = 1'b0;
                    hold(clk_in, $urandom_range(1, 3));
                    enable = 1'b1;
                end
                1: begin
                    @(negedge clk); reset = 1'b1;
                    hold(clk_in, $urandom_range(2, 4));
                    reset = 1'b0;
                end
                2: hold(1'($urandom_range(0, 1)), $urandom_range(5, 25));
                3: begin
                    hold(1'b1, 1);
                    hold(1'b0, $urandom_range(1, 4));
                end
                default: begin
                    n  = $urandom_range(2, MAX_N);
                    hi = $urandom_range(1, n - 1);
                    k  = $urandom_range(2, 6);
                    expected_n = ($urandom_range(0, 1) == 1) ? CW'(n) : CW'($urandom_range(1, MAX_N));
                    run_div(n, hi, k);
                end
            endcase
        end

        hold(1'b0, 4);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
